// File: rtl/counter_sequencer.sv
// Purpose : steps an external prime/Fibonacci counter through its four modes
//           (prime up, prime down, Fibonacci up, Fibonacci down). Each mode is
//           selected, left to settle with the counter disabled, then run for
//           a captured number of advances.
// Latency : start -> LOAD on the next edge. Each mode takes 1 LOAD cycle,
//           SETTLE settle cycles and steps RUN cycles. done is asserted one
//           cycle after the last advance of mode 3, or one cycle after abort.
// Backpr. : hold suspends stepping. enable drops in the same cycle hold is
//           seen, and stepping resumes in the first cycle hold is low again.
//           abort overrides hold, start and step completion.
//
// Parameters
//   SETTLE   : number of enable-low cycles after each mode change (1..7)
//   LOOP_DEF : reset value of the captured loop flag
//
// Ports
//   i_clk      : clock; all state changes on its rising edge
//   i_reset    : asynchronous, active-high reset
//   i_start    : one-cycle start request; accepted only in IDLE or DONE
//   i_hold     : level input; suspends stepping while high
//   i_abort    : one-cycle request to end the schedule immediately
//   i_steps    : advances per mode, captured at start (0 is treated as 1)
//   i_loop     : captured at start; 1 = wrap from mode 3 back to mode 0
//   i_cnt_q    : present value of the attached counter
//   o_PorF     : counter family (0 = prime, 1 = Fibonacci)
//   o_UorD     : counter direction (0 = up, 1 = down)
//   o_enable   : counter enable
//   o_mode_id  : current mode index
//   o_busy     : high in every state except IDLE and DONE
//   o_wrap     : one-cycle pulse after the counter hits the mode's end value
//   o_done     : one-cycle pulse on entering DONE
//   o_step_cnt : advances made in the current mode (saturates at 63)

module counter_sequencer #(
    parameter int SETTLE   = 2,
    parameter bit LOOP_DEF = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_hold,
    input  logic       i_abort,
    input  logic [5:0] i_steps,
    input  logic       i_loop,
    input  logic [5:0] i_cnt_q,
    output logic       o_PorF,
    output logic       o_UorD,
    output logic       o_enable,
    output logic [1:0] o_mode_id,
    output logic       o_busy,
    output logic       o_wrap,
    output logic       o_done,
    output logic [5:0] o_step_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time range check on the settle length
    // ------------------------------------------------------------------
    if (SETTLE < 1 || SETTLE > 7) begin : g_settle_range
        $error("counter_sequencer: SETTLE must be in 1..7");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Settle counter is loaded with SETTLE-1 and runs down to zero, so the
    // SETTLE state lasts exactly SETTLE cycles.
    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE - 1);

    localparam logic [5:0] STEP_MAX = 6'd63;

    // Last value of each counter sequence, indexed by mode.
    localparam logic [5:0] EOS_PRIME_UP = 6'd31;
    localparam logic [5:0] EOS_PRIME_DN = 6'd2;
    localparam logic [5:0] EOS_FIB_UP   = 6'd55;
    localparam logic [5:0] EOS_FIB_DN   = 6'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [1:0] r_mode;
    logic [5:0] r_step_cnt;
    logic [5:0] r_steps;
    logic       r_loop;
    logic [2:0] r_settle_cnt;
    logic       r_PorF;
    logic       r_UorD;
    logic       r_wrap;
    logic       r_done;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic       w_idle_like;
    logic       w_capture;
    logic       w_enable;
    logic       w_last;
    logic [5:0] w_steps_cap;
    logic [5:0] w_eos;
    logic [2:0] w_state_nxt;
    logic [1:0] w_mode_nxt;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

    // A new schedule is accepted only when idle and not cancelled by a
    // simultaneous abort.
    assign w_capture   = w_idle_like && i_start && !i_abort;

    assign w_steps_cap = (i_steps == 6'd0) ? 6'd1 : i_steps;

    // PAUSE with hold released behaves as a RUN cycle. This makes a hold of
    // N cycles cost exactly N enable-low cycles. enable is a function of
    // the state register, so an asynchronous reset drops it immediately.
    assign w_enable = ((r_state == S_RUN) || (r_state == S_PAUSE))
                      && !i_hold && !i_abort;

    // Final advance of the current mode.
    assign w_last = w_enable && (r_step_cnt == (r_steps - 6'd1));

    always_comb begin
        w_eos = EOS_PRIME_UP;
        case (r_mode)
            2'd0: w_eos = EOS_PRIME_UP;
            2'd1: w_eos = EOS_PRIME_DN;
            2'd2: w_eos = EOS_FIB_UP;
            2'd3: w_eos = EOS_FIB_DN;
            default: w_eos = EOS_PRIME_UP;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_capture) begin
                    w_state_nxt = S_LOAD;
                    w_mode_nxt  = 2'd0;
                end
            end
            S_LOAD: begin
                if (i_abort) w_state_nxt = S_DONE;
                else         w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                // hold is deliberately ignored here; the countdown never
                // stalls, and hold takes effect on the first RUN cycle.
                if (i_abort)                   w_state_nxt = S_DONE;
                else if (r_settle_cnt == 3'd0) w_state_nxt = S_RUN;
            end
            S_RUN, S_PAUSE: begin
                if (i_abort) begin
                    w_state_nxt = S_DONE;
                end else if (i_hold) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_last) begin
                    if ((r_mode == 2'd3) && !r_loop) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // Mode 3 + 1 wraps to mode 0 in two bits.
                        w_state_nxt = S_LOAD;
                        w_mode_nxt  = r_mode + 2'd1;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_mode_nxt  = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and mode index
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Schedule parameters captured at start
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_steps <= 6'd1;
            r_loop  <= LOOP_DEF;
        end else if (w_capture) begin
            r_steps <= w_steps_cap;
            r_loop  <= i_loop;
        end
    end

    // ------------------------------------------------------------------
    // Counter selects: updated only when entering LOAD, so they stay stable
    // through SETTLE, RUN and PAUSE, and the counter always sees a settle
    // window before it is enabled in a new mode.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_PorF <= 1'b0;
            r_UorD <= 1'b0;
        end else if (w_state_nxt == S_LOAD) begin
            r_PorF <= w_mode_nxt[1];
            r_UorD <= w_mode_nxt[0];
        end
    end

    // ------------------------------------------------------------------
    // Settle countdown
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_settle_cnt <= 3'd0;
        end else if (r_state == S_LOAD) begin
            r_settle_cnt <= SETTLE_INIT;
        end else if ((r_state == S_SETTLE) && (r_settle_cnt != 3'd0)) begin
            r_settle_cnt <= r_settle_cnt - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Step counter: cleared on every LOAD entry. Otherwise it counts each
    // enabled cycle. An abort leaves it untouched so it can be inspected
    // in DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_step_cnt <= 6'd0;
        end else if (w_state_nxt == S_LOAD) begin
            r_step_cnt <= 6'd0;
        end else if (w_enable && (r_step_cnt != STEP_MAX)) begin
            r_step_cnt <= r_step_cnt + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_wrap <= w_enable && (i_cnt_q == w_eos);
            r_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_PorF     = r_PorF;
    assign o_UorD     = r_UorD;
    assign o_enable   = w_enable;
    assign o_mode_id  = r_mode;
    assign o_busy     = !w_idle_like;
    assign o_wrap     = r_wrap;
    assign o_done     = r_done;
    assign o_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_counter_sequencer.sv
// Purpose : directed-vector bench for counter_sequencer (SETTLE=2, LOOP_DEF=0)
// Latency : checks are made 1-2 ns after each rising edge
// Backpr. : hold and abort are driven per cycle from the directed scenarios

module tb_counter_sequencer;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic       i_hold;
    logic       i_abort;
    logic [5:0] i_steps;
    logic       i_loop;
    logic [5:0] i_cnt_q;
    logic       o_PorF;
    logic       o_UorD;
    logic       o_enable;
    logic [1:0] o_mode_id;
    logic       o_busy;
    logic       o_wrap;
    logic       o_done;
    logic [5:0] o_step_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Prime-up counter model attached to the sequencer.
    logic [5:0] primes [0:11];
    int         pidx;
    logic       cnt_clr;

    counter_sequencer #(.SETTLE(2), .LOOP_DEF(1'b0)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_hold     (i_hold),
        .i_abort    (i_abort),
        .i_steps    (i_steps),
        .i_loop     (i_loop),
        .i_cnt_q    (i_cnt_q),
        .o_PorF     (o_PorF),
        .o_UorD     (o_UorD),
        .o_enable   (o_enable),
        .o_mode_id  (o_mode_id),
        .o_busy     (o_busy),
        .o_wrap     (o_wrap),
        .o_done     (o_done),
        .o_step_cnt (o_step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr)                  pidx <= 0;
        else if (o_enable && pidx < 11) pidx <= pidx + 1;
    end
    assign i_cnt_q = primes[pidx];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse. On return the bench is in cycle 0 (LOAD of mode 0).
    task automatic go(input int s, input int l);
        i_steps = 6'(s);
        i_loop  = l[0];
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // steps=4, loop=0 schedule. Each mode is 7 cycles: LOAD, 2 SETTLE, 4 RUN.
    // hc >= 0 holds for 3 cycles starting at cycle hc.
    task automatic run4(input int hc);
        int last;
        int en_total;
        int e;
        int ph;
        int xen;
        int xstep;
        int xmode;
        last     = (hc < 0) ? 28 : 31;
        en_total = 0;
        go(4, 0);
        for (int c = 0; c <= last; c++) begin
            i_hold = (hc >= 0) && (c >= hc) && (c < hc + 3);
            #1;
            if (c == last) begin
                chk("end_done",   int'(o_done),     1);
                chk("end_busy",   int'(o_busy),     0);
                chk("end_mode",   int'(o_mode_id),  3);
                chk("end_step",   int'(o_step_cnt), 4);
                chk("end_enable", int'(o_enable),   0);
            end else begin
                if (i_hold) begin
                    xen   = 0;
                    xstep = (hc % 7) - 3;
                    xmode = hc / 7;
                end else begin
                    e     = (hc >= 0 && c >= hc + 3) ? c - 3 : c;
                    ph    = e % 7;
                    xen   = (ph >= 3) ? 1 : 0;
                    xstep = (ph >= 3) ? ph - 3 : 0;
                    xmode = e / 7;
                end
                chk("enable", int'(o_enable),   xen);
                chk("step",   int'(o_step_cnt), xstep);
                chk("mode",   int'(o_mode_id),  xmode);
                chk("PorF",   int'(o_PorF),     xmode / 2);
                chk("UorD",   int'(o_UorD),     xmode % 2);
                chk("early_done", int'(o_done), 0);
            end
            en_total += int'(o_enable);
            tick();
        end
        i_hold = 1'b0;
        chk("enable_total", en_total, 16);
        chk("done_width", int'(o_done), 0);
    endtask

    initial begin
        int first;
        int nwrap;
        int wcyc;

        primes[0] = 6'd2;   primes[1] = 6'd3;   primes[2]  = 6'd5;
        primes[3] = 6'd7;   primes[4] = 6'd11;  primes[5]  = 6'd13;
        primes[6] = 6'd17;  primes[7] = 6'd19;  primes[8]  = 6'd23;
        primes[9] = 6'd29;  primes[10] = 6'd31; primes[11] = 6'd37;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_hold  = 1'b0;
        i_abort = 1'b0;
        i_steps = 6'd0;
        i_loop  = 1'b0;
        cnt_clr = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_PorF",   int'(o_PorF),     0);
        chk("rst_UorD",   int'(o_UorD),     0);
        chk("rst_enable", int'(o_enable),   0);
        chk("rst_mode",   int'(o_mode_id),  0);
        chk("rst_step",   int'(o_step_cnt), 0);
        chk("rst_busy",   int'(o_busy),     0);
        chk("rst_wrap",   int'(o_wrap),     0);
        chk("rst_done",   int'(o_done),     0);
        i_reset = 1'b0;
        cnt_clr = 1'b0;
        tick();
        chk("idle_busy", int'(o_busy), 0);

        // Plain four-mode schedule, then the same with a 3-cycle hold
        // starting at the 2nd RUN cycle of mode 1 (cycle 11).
        run4(-1);
        run4(11);

        // steps=0 behaves as steps=1: 4 cycles per mode, done at cycle 16.
        first = -1;
        go(0, 0);
        for (int c = 0; c <= 30; c++) begin
            if (o_done && first < 0) first = c;
            tick();
        end
        chk("steps0_done_cycle", first, 16);

        // Wrap: prime-up counter starting at 2, steps=11. Abort in mode 1 SETTLE.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        nwrap = 0;
        wcyc  = -1;
        go(11, 0);
        for (int c = 0; c <= 15; c++) begin
            i_abort = (c == 15);
            #1;
            if (o_wrap) begin
                nwrap++;
                if (wcyc < 0) wcyc = c;
            end
            if (c == 15) chk("abort_enable_settle", int'(o_enable), 0);
            tick();
        end
        i_abort = 1'b0;
        chk("wrap_count", nwrap, 1);
        chk("wrap_cycle", wcyc, 14);
        chk("abort_done", int'(o_done),     1);
        chk("abort_busy", int'(o_busy),     0);
        chk("abort_mode", int'(o_mode_id),  1);
        chk("abort_PorF", int'(o_PorF),     0);
        chk("abort_UorD", int'(o_UorD),     1);
        chk("abort_step", int'(o_step_cnt), 0);
        tick();
        chk("abort_done_width", int'(o_done), 0);

        // loop=1, steps=2: 5 cycles per mode, mode 0 again at cycle 20.
        // Abort on the last advance of the second pass through mode 0.
        go(2, 1);
        for (int c = 0; c <= 24; c++) begin
            i_abort = (c == 24);
            #1;
            chk("loop_no_done", int'(o_done), 0);
            if (c == 15) chk("loop_mode3", int'(o_mode_id), 3);
            if (c == 19) chk("loop_mode3_en", int'(o_enable), 1);
            if (c == 20) begin
                chk("loop_wrap_mode", int'(o_mode_id), 0);
                chk("loop_busy",      int'(o_busy),    1);
            end
            if (c == 24) begin
                chk("loop_step_pre", int'(o_step_cnt), 1);
                chk("loop_abort_en", int'(o_enable),   0);
            end
            tick();
        end
        i_abort = 1'b0;
        chk("loop_abort_done", int'(o_done),     1);
        chk("loop_abort_busy", int'(o_busy),     0);
        chk("loop_abort_mode", int'(o_mode_id),  0);
        chk("loop_abort_step", int'(o_step_cnt), 1);
        chk("loop_abort_PorF", int'(o_PorF),     0);
        chk("loop_abort_UorD", int'(o_UorD),     0);

        // Reset during RUN of mode 2 (cycle 18, second RUN cycle).
        go(4, 0);
        repeat (18) tick();
        #1;
        chk("pre_rst_PorF", int'(o_PorF),     1);
        chk("pre_rst_UorD", int'(o_UorD),     0);
        chk("pre_rst_en",   int'(o_enable),   1);
        chk("pre_rst_mode", int'(o_mode_id),  2);
        chk("pre_rst_step", int'(o_step_cnt), 1);
        i_reset = 1'b1;
        #1;
        chk("async_PorF", int'(o_PorF),     0);
        chk("async_UorD", int'(o_UorD),     0);
        chk("async_en",   int'(o_enable),   0);
        chk("async_mode", int'(o_mode_id),  0);
        chk("async_step", int'(o_step_cnt), 0);
        chk("async_busy", int'(o_busy),     0);
        chk("async_done", int'(o_done),     0);
        tick();
        chk("rst_hold_done", int'(o_done), 0);
        tick();
        i_reset = 1'b0;
        tick();
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_done", int'(o_done), 0);

        // start and abort together in IDLE: stays IDLE.
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("sa_busy", int'(o_busy), 0);
        chk("sa_done", int'(o_done), 0);
        tick();
        chk("sa_busy2", int'(o_busy), 0);

        // Restart after reset, then start while busy is ignored.
        go(4, 0);
        #1;
        chk("restart_busy", int'(o_busy),    1);
        chk("restart_mode", int'(o_mode_id), 0);
        chk("restart_en",   int'(o_enable),  0);
        repeat (4) tick();
        #1;
        chk("restart_run_en",   int'(o_enable),   1);
        chk("restart_run_step", int'(o_step_cnt), 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        #1;
        chk("busy_start_mode", int'(o_mode_id),  0);
        chk("busy_start_step", int'(o_step_cnt), 2);
        chk("busy_start_busy", int'(o_busy),     1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("final_done", int'(o_done),     1);
        chk("final_step", int'(o_step_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
